ps2_rx: RTL and testbench

- PS/2 keyboard receiver; sits directly upstream of the scan-code-to-ASCII translator.
- Synchronises and filters the raw PS/2 clock and data lines.
- Deserialises 11-bit device-to-host frames and checks parity and stop bit.
- Maintains a 24-bit history of the last three good scan-code bytes; the translator consumes this as its iDATA.

---
 rtl/ps2_rx.sv | 117 +++++++++++
 tb/tb_ps2_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the pin lines, deserialises
// 11-bit frames and keeps a three-byte history of good scan codes for the translator.
//
// state | meaning
// IDLE  | waiting for a falling edge with data low (start bit)
// RECV  | shifting in data, parity and stop bits; watching the inter-edge timeout
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iPS2_CLK,
    input  logic        iPS2_DAT,
    output logic [23:0] oDATA,
    output logic        oVALID,
    output logic        oERR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic                  r_clk_s1, r_clk_s2;
    logic                  r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk, r_fclk_d;
    state_t                r_state;
    logic [3:0]            r_bitcnt;
    logic [TW-1:0]         r_tcnt;
    logic [7:0]            r_shift;
    logic                  r_par;

    logic          w_fe;
    logic          w_good;
    logic [TW-1:0] w_tcnt_nxt;

    assign w_fe       = r_fclk_d & ~r_fclk;
    assign w_good     = (^{r_shift, r_par}) & r_dat_s2;
    assign w_tcnt_nxt = r_tcnt + TW'(1);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= '1;
            r_fclk   <= 1'b1;
            r_fclk_d <= 1'b1;
        end else begin
            r_clk_s1 <= iPS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= iPS2_DAT;
            r_dat_s2 <= r_dat_s1;
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
            // Filtered clock only moves once every tap agrees; otherwise it holds.
            if (&r_filt)
                r_fclk <= 1'b1;
            else if (~|r_filt)
                r_fclk <= 1'b0;
            r_fclk_d <= r_fclk;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            oDATA    <= '0;
            oVALID   <= 1'b0;
            oERR     <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            oERR   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fe && !r_dat_s2) begin
                        r_state  <= RECV;
                        r_bitcnt <= '0;
                        r_tcnt   <= '0;
                    end
                end
                RECV: begin
                    if (w_fe) begin
                        r_tcnt   <= '0;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt < 4'd8)
                            r_shift <= {r_dat_s2, r_shift[7:1]};
                        else if (r_bitcnt == 4'd8)
                            r_par <= r_dat_s2;
                        else begin
                            r_state <= IDLE;
                            if (w_good) begin
                                oDATA  <= {oDATA[15:0], r_shift};
                                oVALID <= 1'b1;
                            end else
                                oERR <= 1'b1;
                        end
                    end else if (w_tcnt_nxt == TC_LAST) begin
                        // Device stalled mid-frame: drop the partial byte.
                        r_state <= IDLE;
                        r_tcnt  <= '0;
                        oERR    <= 1'b1;
                    end else
                        r_tcnt <= w_tcnt_nxt;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of whole frames plus hand sequences for glitches,
// timeout and mid-frame reset.
module tb_ps2_rx;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iPS2_CLK = 1'b1;
    logic        iPS2_DAT = 1'b1;
    logic [23:0] oDATA;
    logic        oVALID;
    logic        oERR;

    ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
        .iCLK(iCLK), .iRST(iRST), .iPS2_CLK(iPS2_CLK), .iPS2_DAT(iPS2_DAT),
        .oDATA(oDATA), .oVALID(oVALID), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    int cnt_valid = 0;
    int cnt_err = 0;
    int cnt_both = 0;
    int err_cyc = 0;
    int last_fall = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge iCLK) cyc = cyc + 1;

    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oVALID) cnt_valid = cnt_valid + 1;
            if (oERR) begin
                cnt_err = cnt_err + 1;
                err_cyc = cyc;
            end
            if (oVALID && oERR) cnt_both = cnt_both + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data set mid-high, 40-cycle low phase, optional 3-cycle glitch in the high phase.
    task automatic ps2_bit(input logic b, input logic glitch);
        iPS2_DAT = b;
        tick(20);
        iPS2_CLK  = 1'b0;
        last_fall = cyc;
        tick(40);
        iPS2_CLK = 1'b1;
        if (glitch) begin
            tick(5);
            iPS2_CLK = 1'b0;
            tick(3);
            iPS2_CLK = 1'b1;
            tick(12);
        end else
            tick(20);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], i == glitch_bit);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, 1'b0);
        iPS2_DAT = 1'b1;
        tick(30);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        par;
        logic        stop;
        int          ev;
        int          ee;
        logic [23:0] edata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, e0, k, lat;
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 24'h00001C};
        vecs[1] = '{8'hE0, 1'b0, 1'b1, 1, 0, 24'h001CE0};
        vecs[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 24'h1CE0F0};
        vecs[3] = '{8'h75, 1'b0, 1'b1, 1, 0, 24'hE0F075};
        vecs[4] = '{8'h1C, 1'b1, 1'b1, 0, 1, 24'hE0F075};
        vecs[5] = '{8'h1C, 1'b0, 1'b0, 0, 1, 24'hE0F075};

        tick(3);
        chk("reset_data", oDATA, 24'h0);
        chk("reset_valid", oVALID, 0);
        chk("reset_err", oERR, 0);
        iRST = 1'b0;
        tick(20);

        for (int i = 0; i < 6; i++) begin
            v0 = cnt_valid;
            e0 = cnt_err;
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, -1);
            chk($sformatf("vec%0d_valid", i), cnt_valid - v0, vecs[i].ev);
            chk($sformatf("vec%0d_err", i), cnt_err - e0, vecs[i].ee);
            chk($sformatf("vec%0d_data", i), oDATA, vecs[i].edata);
        end

        // Glitches between frames and inside a frame must not create edges.
        v0 = cnt_valid;
        e0 = cnt_err;
        iPS2_CLK = 1'b0;
        tick(3);
        iPS2_CLK = 1'b1;
        tick(20);
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        chk("glitch_valid", cnt_valid - v0, 1);
        chk("glitch_err", cnt_err - e0, 0);
        chk("glitch_data", oDATA, 24'hF0751C);

        // Start plus four data bits, then the clock stalls high.
        v0 = cnt_valid;
        e0 = cnt_err;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        iPS2_DAT = 1'b1;
        k = 0;
        while (cnt_err == e0 && k < 400) begin
            tick(1);
            k++;
        end
        lat = err_cyc - last_fall;
        chk("timeout_err", cnt_err - e0, 1);
        chk("timeout_latency_ok", (lat >= 208 && lat <= 214), 1);
        chk("timeout_valid", cnt_valid - v0, 0);
        chk("timeout_data", oDATA, 24'hF0751C);
        tick(20);
        send_frame(8'h29, 1'b0, 1'b1, -1);
        chk("after_timeout_byte", oDATA[7:0], 8'h29);
        chk("after_timeout_data", oDATA, 24'h751C29);

        // Reset after five bits of a 0x12 frame, then the remainder of that frame.
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        iRST = 1'b1;
        tick(1);
        chk("midrst_data", oDATA, 24'h0);
        chk("midrst_valid", oVALID, 0);
        chk("midrst_err", oERR, 0);
        iRST = 1'b0;
        v0 = cnt_valid;
        e0 = cnt_err;
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        iPS2_DAT = 1'b1;
        tick(300);
        chk("midrst_no_valid", cnt_valid - v0, 0);
        chk("midrst_err_at_most_one", (cnt_err - e0) <= 1, 1);
        chk("midrst_data_held", oDATA, 24'h0);
        v0 = cnt_valid;
        send_frame(8'h12, 1'b1, 1'b1, -1);
        chk("post_rst_valid", cnt_valid - v0, 1);
        chk("post_rst_data", oDATA, 24'h000012);

        chk("never_both", cnt_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
